// File: rtl/dither_result_tx_pkg.sv
// states: FSM encodings shared across the dither pipeline.
// tx_state_t includes TX_PACK only when TX_PACK_1BPP_EN is defined.
package states;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DITHER,
    ST_STORE
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_READ,
    TX_WAITQ,
`ifdef TX_PACK_1BPP_EN
    TX_PACK,
`endif
    TX_HOLD,
    TX_SHIFT,
    TX_GAP,
    TX_FIN
  } tx_state_t;

endpackage

// File: rtl/dither_result_tx_shifter.sv
// spi_byte_shifter: sends one byte as an SPI mode-0 frame, MSB first.
// It waits in HOLD for the MCU, shifts in SHIFT, then closes the frame with a GAP.
module spi_byte_shifter
  import states::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       ready_i,
  output logic       sclk_o,
  output logic       miso_o,
  output logic       cs_n_o,
  output logic       frame_done_o
);

  localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  tx_state_t        phase_q, phase_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             miso_q, miso_d;
  logic             cs_n_q, cs_n_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every value assigned below gets a default first, so no path infers a latch.
    phase_d      = phase_q;
    sreg_d       = sreg_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sclk_d       = sclk_q;
    miso_d       = miso_q;
    cs_n_d       = cs_n_q;
    frame_done_o = 1'b0;
    unique case (phase_q)
      TX_HOLD: begin
        if (ready_i) begin
          cs_n_d  = 1'b0;
          miso_d  = sreg_q[7];
          div_d   = '0;
          bit_d   = '0;
          phase_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          // Data advances on the falling edge; the eighth falling edge closes the frame.
          if (sclk_q) begin
            if (bit_q == 3'd7) begin
              cs_n_d  = 1'b1;
              miso_d  = 1'b0;
              phase_d = TX_GAP;
            end else begin
              bit_d  = bit_q + 3'd1;
              sreg_d = {sreg_q[6:0], 1'b0};
              miso_d = sreg_q[6];
            end
          end
        end
      end
      TX_GAP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          frame_done_o = 1'b1;
          phase_d      = TX_IDLE;
        end
      end
      default: begin
        if (load_i) begin
          sreg_d  = byte_i;
          phase_d = TX_HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= TX_IDLE;
      sreg_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      miso_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      miso_q  <= miso_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sclk_o = sclk_q;
  assign miso_o = miso_q;
  assign cs_n_o = cs_n_q;

endmodule

// File: rtl/dither_result_tx.sv
// dither_result_tx: reads the dithered image back from SRAM and streams it to the MCU over SPI.
// Define TX_PACK_1BPP_EN to pack the MSBs of 8 consecutive pixels into each byte frame.
module dither_result_tx
  import states::*;
#(
  parameter int IMAGEX           = 16,
  parameter int IMAGEY           = 16,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int SCLK_DIV         = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  output logic                        sram_rden,
  input  logic [RGB_SIZE-1:0]         sram_q,
  input  logic                        mcu_ready,
  output logic                        spi_sclk,
  output logic                        spi_miso,
  output logic                        spi_cs_n,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  tx_state_t                   state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                  byte_q, byte_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        load_q, load_d;
  logic                        frame_done;
  logic                        unused_sram_bits;
`ifdef TX_PACK_1BPP_EN
  logic [2:0]                  pack_q, pack_d;
`endif

  // Only the top byte (or just the MSB when packing) of each pixel is transmitted.
  assign unused_sram_bits = ^sram_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
`ifdef TX_PACK_1BPP_EN
    pack_d  = pack_q;
`endif
    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          state_d = TX_READ;
        end
      end
      TX_READ: state_d = TX_WAITQ;
      TX_WAITQ: begin
`ifdef TX_PACK_1BPP_EN
        byte_d  = {byte_q[6:0], sram_q[RGB_SIZE-1]};
        state_d = TX_PACK;
`else
        byte_d  = sram_q[RGB_SIZE-1 -: 8];
        load_d  = 1'b1;
        state_d = TX_HOLD;
`endif
      end
`ifdef TX_PACK_1BPP_EN
      TX_PACK: begin
        pack_d = pack_q + 3'd1;
        if (pack_q == 3'd7) begin
          load_d  = 1'b1;
          state_d = TX_HOLD;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = TX_READ;
        end
      end
`endif
      // The top FSM parks in HOLD for the whole frame; the shifter splits it into HOLD, SHIFT and GAP.
      TX_HOLD: begin
        if (frame_done) begin
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = TX_FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = TX_READ;
          end
        end
      end
      TX_FIN: begin
        addr_d  = '0;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
`ifdef TX_PACK_1BPP_EN
      pack_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
`ifdef TX_PACK_1BPP_EN
      pack_q  <= pack_d;
`endif
    end
  end

  spi_byte_shifter #(
    .SCLK_DIV(SCLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load_q),
    .byte_i      (byte_q),
    .ready_i     (mcu_ready),
    .sclk_o      (spi_sclk),
    .miso_o      (spi_miso),
    .cs_n_o      (spi_cs_n),
    .frame_done_o(frame_done)
  );

  assign sram_addr = addr_q;
  assign sram_rden = (state_q == TX_READ);
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dither_result_tx.sv
// tb_dither_result_tx: random and directed stimulus against a frame-level model of the image readback.
module tb_dither_result_tx;

  localparam int SCLK_DIV = 2;
  localparam int NPIX     = 256;
`ifdef TX_PACK_1BPP_EN
  localparam int PPF      = 8;
`else
  localparam int PPF      = 1;
`endif
  localparam int FRAMES   = NPIX / PPF;
  localparam int HOLD_ADDR = 3 * PPF - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sram_addr;
  logic       sram_rden;
  logic [7:0] sram_q = '0;
  logic       mcu_ready = 1'b1;
  logic       spi_sclk, spi_miso, spi_cs_n, busy, done;

  dither_result_tx #(
    .IMAGEX(16), .IMAGEY(16), .IMAGE_SIZE(256), .IMAGE_ADDR_WIDTH(8), .RGB_SIZE(8), .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sram_addr(sram_addr), .sram_rden(sram_rden),
    .sram_q(sram_q), .mcu_ready(mcu_ready), .spi_sclk(spi_sclk), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:NPIX-1];
  always @(posedge clk) if (sram_rden) sram_q <= mem[sram_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the ordered list of bytes the MCU must receive.
  logic [7:0] exp_q [$];
  logic [7:0] rx_log [0:NPIX-1];
  int         frames_rx = 0;

  task automatic load_model();
    logic [7:0] b;
    exp_q.delete();
    for (int f = 0; f < FRAMES; f++) begin
      b = '0;
      if (PPF == 1) b = mem[f];
      else for (int j = 0; j < 8; j++) b[7-j] = mem[f*8+j][7];
      exp_q.push_back(b);
    end
  endtask

  // SPI receiver and per-cycle protocol checker.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       m_cs = 1'b1, m_sclk = 1'b0, m_miso = 1'b0;
  logic [7:0] rx = '0;
  int         nbits = 0;
  int unsigned cs_fall_cyc = 0, cs_rise_cyc = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_cs = 1'b1; m_sclk = 1'b0; m_miso = 1'b0; nbits = 0;
    end else begin
      if (spi_cs_n) check("sclk_idle_low", spi_sclk, 1'b0);
      if (spi_miso !== m_miso)
        check("miso_moves_on_fall", (m_sclk && !spi_sclk) || (m_cs && !spi_cs_n), 1'b1);
      if (m_cs && !spi_cs_n) begin
        check("gap_min", (cyc - cs_rise_cyc) >= SCLK_DIV, 1'b1);
        cs_fall_cyc = cyc; nbits = 0; rx = '0;
      end
      if (!m_sclk && spi_sclk) begin
        nbits++;
        rx = {rx[6:0], spi_miso};
        check("sclk_rise_time", cyc - cs_fall_cyc, SCLK_DIV * (2 * nbits - 1));
      end
      if (!m_cs && spi_cs_n) begin
        cs_rise_cyc = cyc;
        check("bits_per_frame", nbits, 8);
        check("frame_len", cyc - cs_fall_cyc, 16 * SCLK_DIV);
        check("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check($sformatf("frame%0d_data", frames_rx), rx, exp_q.pop_front());
        if (frames_rx < NPIX) rx_log[frames_rx] = rx;
        frames_rx++;
      end
      m_cs = spi_cs_n; m_sclk = spi_sclk; m_miso = spi_miso;
    end
  end

  task automatic do_start();
    frames_rx = 0;
    load_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_frames(input int n, input int budget, input string what);
    int k = 0;
    while (frames_rx < n && k < budget) begin @(negedge clk); k++; end
    check({"reach_", what}, frames_rx >= n, 1'b1);
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk); k++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check("busy_low_with_done", busy, 1'b0);
        check("frames_at_done", frames_rx, FRAMES);
        check("model_drained", exp_q.size(), 0);
      end else begin
        check("busy_while_running", busy, 1'b1);
        if (rnd) begin
          mcu_ready = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 499) == 0) start = 1'b1;
        end
      end
    end
    check("done_within_budget", seen, 1'b1);
    start = 1'b0;
    mcu_ready = 1'b1;
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("idle_busy_low", busy, 1'b0);
    check("idle_addr_zero", sram_addr, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_rden"}, sram_rden, 1'b0);
    check({tag, "_sclk"}, spi_sclk, 1'b0);
    check({tag, "_miso"}, spi_miso, 1'b0);
    check({tag, "_cs_n"}, spi_cs_n, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset held while start pulses: nothing may happen.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_no_rden", sram_rden, 1'b0);
      check("reset_cs_high", spi_cs_n, 1'b1);
      check("reset_busy_low", busy, 1'b0);
    end
    start = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Random image, random mcu_ready, stray starts while busy.
`ifdef TX_PACK_1BPP_EN
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'hFF;
    mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'hFF;
`else
    mem[0] = 8'hA5;
`endif
    do_start();
    wait_done(1'b1, 40000);
`ifdef TX_PACK_1BPP_EN
    check("first_frame_literal", rx_log[0], 8'hB1);
`else
    check("first_frame_literal", rx_log[0], 8'hA5);
`endif

    // Ramp image with mcu_ready held high.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    do_start();
    wait_done(1'b0, 30000);
`ifdef TX_PACK_1BPP_EN
    check("ramp_f0", rx_log[0], 8'h00);
    check("ramp_f15", rx_log[15], 8'h00);
    check("ramp_f16", rx_log[16], 8'hFF);
    check("ramp_f31", rx_log[31], 8'hFF);
`else
    check("ramp_f0", rx_log[0], 8'h00);
    check("ramp_f1", rx_log[1], 8'h01);
    check("ramp_f127", rx_log[127], 8'h7F);
    check("ramp_f255", rx_log[255], 8'hFF);
`endif

    // Back-pressure before frame 3, then mcu_ready dropped inside frame 4.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    do_start();
    wait_frames(2, 2000, "frame2");
    mcu_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("stall_cs_high", spi_cs_n, 1'b1);
      if (i >= 10) check("stall_addr_held", sram_addr, HOLD_ADDR);
    end
    check("stall_no_frames", frames_rx, 2);
    mcu_ready = 1'b1;
    k = 0;
    while (!(frames_rx == 3 && !spi_cs_n) && k < 500) begin @(negedge clk); k++; end
    check("frame4_started", frames_rx == 3 && !spi_cs_n, 1'b1);
    repeat (6) @(negedge clk);
    mcu_ready = 1'b0;
    wait_frames(4, 200, "frame4_done");
    mcu_ready = 1'b1;
    wait_done(1'b0, 30000);

    // Reset in the middle of frame 10, then a clean restart.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    do_start();
    wait_frames(9, 3000, "frame9");
    k = 0;
    while (spi_cs_n && k < 200) begin @(negedge clk); k++; end
    check("frame10_started", spi_cs_n, 1'b0);
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_no_done", done, 1'b0);
    end
    reset_n = 1'b1;
    exp_q.delete();
`ifdef TX_PACK_1BPP_EN
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'h00;
    mem[4] = 8'hFF; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;
`else
    mem[0] = 8'h3C;
`endif
    do_start();
    wait_done(1'b0, 30000);
`ifdef TX_PACK_1BPP_EN
    check("restart_frame0", rx_log[0], 8'h68);
`else
    check("restart_frame0", rx_log[0], 8'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dither_result_tx.md
DITHER_RESULT_TX -- requirements
Module: dither_result_tx

Interface
REQ-001 SHALL have parameter IMAGEX, default 16, image width in pixels.
REQ-002 SHALL have parameter IMAGEY, default 16, image height in pixels.
REQ-003 SHALL have parameters IMAGE_SIZE (default IMAGEX*IMAGEY) and IMAGE_ADDR_WIDTH (default $clog2(IMAGE_SIZE)), giving pixel count and address width.
REQ-004 SHALL have parameter RGB_SIZE, default 8, bits per stored pixel.
REQ-005 SHALL have parameter SCLK_DIV, default 2, clk cycles per SCLK half-period, minimum 1.
REQ-006 SHALL have port clk  in  1  single system clock.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins readback of the dithered image.
REQ-009 SHALL have port sram_addr  out  IMAGE_ADDR_WIDTH  pixel read address.
REQ-010 SHALL have port sram_rden  out  1  read strobe; data is valid one cycle later.
REQ-011 SHALL have port sram_q  in  RGB_SIZE  read data.
REQ-012 SHALL have port mcu_ready  in  1  level; the MCU can accept a byte.
REQ-013 SHALL have port spi_sclk  out  1  serial clock, idle low.
REQ-014 SHALL have port spi_miso  out  1  serial data, MSB first.
REQ-015 SHALL have port spi_cs_n  out  1  byte frame, active low.
REQ-016 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-017 SHALL have port done  out  1  one-cycle pulse after the last bit frame closes.

Function
REQ-018 SHALL implement the FSM IDLE -> READ -> WAITQ -> (PACK) -> HOLD -> SHIFT -> GAP -> READ or FIN -> IDLE.
REQ-019 SHALL leave IDLE only on start; a start received while busy SHALL be ignored.
REQ-020 READ SHALL assert sram_rden for one cycle at the current address; WAITQ SHALL capture sram_q into the byte register on the next cycle.
REQ-021 HOLD SHALL wait while mcu_ready=0; with mcu_ready=1 it SHALL drive spi_cs_n low and spi_miso to bit 7, then enter SHIFT.
REQ-022 SHIFT mode 0: spi_sclk SHALL rise SCLK_DIV cycles after spi_cs_n falls; spi_miso SHALL change only on falling edges; exactly 8 rising edges per frame.
REQ-023 Deasserting mcu_ready during SHIFT SHALL NOT abort the frame; it is sampled only in HOLD.
REQ-024 GAP SHALL hold spi_cs_n high and spi_sclk low for SCLK_DIV cycles.
REQ-025 After GAP the address SHALL increment, or the FSM SHALL enter FIN after address IMAGE_SIZE-1; the address never wraps within a transfer.
REQ-026 FIN SHALL pulse done for one cycle, reset the address to 0, and return to IDLE.
REQ-027 With RGB_SIZE>8, the block SHALL transmit sram_q[RGB_SIZE-1 -: 8].

Reset
REQ-028 On reset_n low, the block SHALL enter IDLE with sram_addr=0, sram_rden=0, spi_sclk=0, spi_miso=0, spi_cs_n=1, busy=0, done=0, and all counters cleared.
REQ-029 A reset mid-frame SHALL abort immediately with no done pulse; the next start SHALL restart at address 0.

Configuration
REQ-030 With TX_PACK_1BPP_EN defined, PACK SHALL read 8 consecutive pixels and shift each pixel's MSB into the byte, first pixel in bit 7, one frame per 8 pixels, IMAGE_SIZE/8 frames in total; IMAGE_SIZE SHALL be a multiple of 8.
REQ-031 Without TX_PACK_1BPP_EN, the PACK state and its 3-bit counter SHALL be absent, and one frame SHALL be sent per pixel, IMAGE_SIZE frames in total.

Structure
REQ-032 The FSM state enum tx_state_t SHALL live in package states, alongside the existing state_t.
REQ-033 A sub-module spi_byte_shifter SHALL implement HOLD/SHIFT/GAP timing, with ports load, byte, ready, and frame_done.

Verification (IMAGEX=IMAGEY=16, SCLK_DIV=2)
REQ-034 Reset held during start -> spi_cs_n=1, busy=0, and no sram_rden pulses.
REQ-035 SRAM[0]=0xA5, mcu_ready=1, start -> first frame bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges, each sclk edge 2 clk apart.
REQ-036 Ramp SRAM[i]=i, mcu_ready=1 -> 256 frames received equal 0x00..0xFF; done pulses once after frame 256; busy falls with done.
REQ-037 mcu_ready=0 for 50 cycles before frame 3 -> spi_cs_n stays high and sram_addr=2 is held; dropping mcu_ready mid-frame 4 still completes frame 4.
REQ-038 reset_n pulsed low during frame 10 -> outputs at reset values in the same cycle, no done pulse; a new start yields frame 0 = SRAM[0].
REQ-039 TX_PACK_1BPP_EN, pixels 0..7 = FF,00,FF,FF,00,00,00,FF -> first byte 0xB1; 32 frames in total, then done.
